// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types, constants and ASCII lookup for the PS/2 scan-code framer
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_E0      = 8'hE0;
    localparam logic [7:0] PS2_F0      = 8'hF0;
    localparam logic [7:0] PS2_LSHIFT  = 8'h12;
    localparam logic [7:0] PS2_RSHIFT  = 8'h59;
    localparam logic [7:0] PS2_CTRL    = 8'h14;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       rep;
        logic [7:0] ascii;
    } ps2_evt_t;

    localparam int PS2_EVT_W = $bits(ps2_evt_t);

    // Keyboard status/ack bytes that carry no key information outside a prefix
    function automatic logic is_status_byte(input logic [7:0] code);
        return (code == 8'h00) || (code == 8'hAA) || (code == 8'hE1) || (code == 8'hEE) ||
               (code == 8'hFA) || (code == 8'hFE) || (code == 8'hFF);
    endfunction

    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic shift);
        logic [7:0] lower;
        logic       letter;
        lower  = 8'h00;
        letter = 1'b1;
        case (code)
            8'h1C: lower = 8'h61;  8'h32: lower = 8'h62;  8'h21: lower = 8'h63;
            8'h23: lower = 8'h64;  8'h24: lower = 8'h65;  8'h2B: lower = 8'h66;
            8'h34: lower = 8'h67;  8'h33: lower = 8'h68;  8'h43: lower = 8'h69;
            8'h3B: lower = 8'h6A;  8'h42: lower = 8'h6B;  8'h4B: lower = 8'h6C;
            8'h3A: lower = 8'h6D;  8'h31: lower = 8'h6E;  8'h44: lower = 8'h6F;
            8'h4D: lower = 8'h70;  8'h15: lower = 8'h71;  8'h2D: lower = 8'h72;
            8'h1B: lower = 8'h73;  8'h2C: lower = 8'h74;  8'h3C: lower = 8'h75;
            8'h2A: lower = 8'h76;  8'h1D: lower = 8'h77;  8'h22: lower = 8'h78;
            8'h35: lower = 8'h79;  8'h1A: lower = 8'h7A;
            default: letter = 1'b0;
        endcase
        if (letter) begin
            return shift ? (lower - 8'h20) : lower;
        end
        case (code)
            8'h45: return 8'h30;  8'h16: return 8'h31;  8'h1E: return 8'h32;
            8'h26: return 8'h33;  8'h25: return 8'h34;  8'h2E: return 8'h35;
            8'h36: return 8'h36;  8'h3D: return 8'h37;  8'h3E: return 8'h38;
            8'h46: return 8'h39;  8'h29: return 8'h20;  8'h5A: return 8'h0D;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - first-word fall-through event FIFO with full/empty flags
module ps2_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_ready_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = rd_ready_i && !empty_o;
    // When full, a same-cycle pop frees the slot the push lands in
    assign do_push = wr_valid_i && (!full_o || do_pop);
    assign rd_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_framer.sv
// rtl/ps2_scancode_framer.sv - PS/2 prefix parser, modifier tracking and event queueing
module ps2_scancode_framer
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code_data,
    input  logic       code_valid,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       evt_repeat,
    output logic [7:0] evt_ascii,
    output logic       shift_state,
    output logic       ctrl_state,
    output logic [7:0] drop_cnt
);
    ps2_state_e state_q, state_d;
    logic       shift_q, ctrl_q;
    logic [8:0] held_q;
    logic [7:0] drop_q;

    logic       in_ext, in_brk;
    logic       form_evt;
    ps2_evt_t   evt_d;
    ps2_evt_t   head;
    logic [PS2_EVT_W-1:0] fifo_rd_data;
    logic       fifo_full, fifo_empty;

    assign in_ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    assign in_brk = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);

    always_comb begin
        state_d  = state_q;
        form_evt = 1'b0;
        evt_d    = '0;
        if (code_valid) begin
            if (code_data == PS2_E0 && !in_brk) begin
                state_d = ST_EXT;
            end else if (code_data == PS2_F0) begin
                state_d = in_ext ? ST_EXT_BRK : ST_BRK;
            end else if (state_q == ST_IDLE && is_status_byte(code_data)) begin
                state_d = ST_IDLE;
            end else begin
                form_evt    = 1'b1;
                state_d     = ST_IDLE;
                evt_d.code  = code_data;
                evt_d.ext   = in_ext;
                evt_d.brk   = in_brk;
                evt_d.rep   = !in_brk && ({in_ext, code_data} == held_q);
                // Shift as it stood before this byte; modifier update lands with the push
                evt_d.ascii = (in_ext || in_brk) ? 8'h00 : scan_to_ascii(code_data, shift_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= 1'b0;
            ctrl_q  <= 1'b0;
            held_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            if (form_evt) begin
                if (!evt_d.brk) begin
                    held_q <= {evt_d.ext, evt_d.code};
                end else if ({evt_d.ext, evt_d.code} == held_q) begin
                    held_q <= '0;
                end
                if (evt_d.code == PS2_LSHIFT || evt_d.code == PS2_RSHIFT) begin
                    shift_q <= !evt_d.brk;
                end
                if (evt_d.code == PS2_CTRL) begin
                    ctrl_q <= !evt_d.brk;
                end
                if (fifo_full && !evt_ready && drop_q != 8'hFF) begin
                    drop_q <= drop_q + 8'd1;
                end
            end
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PS2_EVT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_valid_i (form_evt),
        .wr_data_i  (evt_d),
        .rd_ready_i (evt_ready),
        .rd_data_o  (fifo_rd_data),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Head fields read as zero while empty so reset leaves every evt_* output at 0
    assign head        = fifo_empty ? '0 : ps2_evt_t'(fifo_rd_data);
    assign evt_valid   = !fifo_empty;
    assign evt_code    = head.code;
    assign evt_ext     = head.ext;
    assign evt_break   = head.brk;
    assign evt_repeat  = head.rep;
    assign evt_ascii   = head.ascii;
    assign shift_state = shift_q;
    assign ctrl_state  = ctrl_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_ps2_scancode_framer.sv
// tb/tb_ps2_scancode_framer.sv - directed and randomized bench for ps2_scancode_framer
module tb_ps2_scancode_framer;
    localparam int FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] code_data = 8'h00;
    logic       code_valid = 1'b0;
    logic       evt_ready = 1'b0;
    logic       evt_valid, evt_ext, evt_break, evt_repeat, shift_state, ctrl_state;
    logic [7:0] evt_code, evt_ascii, drop_cnt;

    int checks = 0;
    int errors = 0;

    ps2_scancode_framer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .code_data   (code_data),
        .code_valid  (code_valid),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_code    (evt_code),
        .evt_ext     (evt_ext),
        .evt_break   (evt_break),
        .evt_repeat  (evt_repeat),
        .evt_ascii   (evt_ascii),
        .shift_state (shift_state),
        .ctrl_state  (ctrl_state),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       rep;
        logic [7:0] ascii;
    } mevt_t;

    mevt_t      mq[$];
    logic       m_ext, m_brk, m_shift, m_ctrl;
    logic [8:0] m_held;
    int         m_drop;

    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                      8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                      8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                      8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                     8'h3E, 8'h46};
    logic [7:0] junk_codes [7] = '{8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

    function automatic logic [7:0] ref_ascii(input logic [7:0] b, input logic shift);
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == b) return (shift ? 8'h41 : 8'h61) + 8'(i);
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == b) return 8'h30 + 8'(i);
        if (b == 8'h29) return 8'h20;
        if (b == 8'h5A) return 8'h0D;
        return 8'h00;
    endfunction

    function automatic logic is_junk(input logic [7:0] b);
        for (int i = 0; i < 7; i++)
            if (junk_codes[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ext = 0; m_brk = 0; m_shift = 0; m_ctrl = 0; m_held = '0; m_drop = 0;
    endtask

    // One clock of the reference: pop (sampled before the edge), then the byte's effect
    task automatic model_cycle(input logic v, input logic [7:0] b);
        mevt_t e;
        logic [8:0] key;
        if (evt_ready && mq.size() > 0) void'(mq.pop_front());
        if (!v) return;
        if (b == 8'hE0 && !m_brk) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (!m_ext && !m_brk && is_junk(b)) begin
            m_ext = 0;
        end else begin
            key     = {m_ext, b};
            e.code  = b;
            e.ext   = m_ext;
            e.brk   = m_brk;
            e.rep   = !m_brk && (key == m_held);
            e.ascii = (m_ext || m_brk) ? 8'h00 : ref_ascii(b, m_shift);
            if (!m_brk) m_held = key;
            else if (key == m_held) m_held = '0;
            if (b == 8'h12 || b == 8'h59) m_shift = !m_brk;
            if (b == 8'h14) m_ctrl = !m_brk;
            if (mq.size() < FIFO_DEPTH) mq.push_back(e);
            else if (m_drop < 255) m_drop++;
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic compare();
        check("evt_valid", 32'(evt_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            check("evt_code", 32'(evt_code), 32'(mq[0].code));
            check("evt_ext", 32'(evt_ext), 32'(mq[0].ext));
            check("evt_break", 32'(evt_break), 32'(mq[0].brk));
            check("evt_repeat", 32'(evt_repeat), 32'(mq[0].rep));
            check("evt_ascii", 32'(evt_ascii), 32'(mq[0].ascii));
        end
        check("shift_state", 32'(shift_state), 32'(m_shift));
        check("ctrl_state", 32'(ctrl_state), 32'(m_ctrl));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    task automatic step(input logic v, input logic [7:0] b);
        @(negedge clk);
        code_valid = v;
        code_data  = b;
        model_cycle(v, b);
        @(posedge clk);
        #1;
        code_valid = 0;
        compare();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(evt_valid), 0);
        check({tag, "_fields"}, {evt_code, evt_ascii, 12'h0, evt_ext, evt_break, evt_repeat, 1'b0}, 0);
        check({tag, "_mods"}, 32'({shift_state, ctrl_state}), 0);
        check({tag, "_drop"}, 32'(drop_cnt), 0);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        rst = 1;
        #1;
        model_reset();
        check_reset_outputs(tag);
        @(negedge clk);
        rst = 0;
    endtask

    logic [7:0] sent [6];
    logic [7:0] b;
    int         cat;

    initial begin
        model_reset();
        #2 rst = 1;
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst = 0;

        evt_ready = 1;
        step(1, 8'h1C);
        check("r030_make_code", 32'(evt_code), 32'h1C);
        check("r030_make_ascii", 32'(evt_ascii), 32'h61);
        check("r030_make_brk", 32'(evt_break), 0);
        step(1, 8'hF0);
        check("r030_prefix_noevt", 32'(evt_valid), 0);
        step(1, 8'h1C);
        check("r030_brk_flag", 32'(evt_break), 1);
        check("r030_brk_ascii", 32'(evt_ascii), 32'h00);
        step(0, 8'h00);

        step(1, 8'h12);
        step(1, 8'h1C);
        check("r031_upper", 32'(evt_ascii), 32'h41);
        check("r031_shift_on", 32'(shift_state), 1);
        step(1, 8'hF0);
        step(1, 8'h12);
        check("r031_shift_off", 32'(shift_state), 0);
        step(0, 8'h00);

        step(1, 8'hE0);
        check("r032_e0_noevt", 32'(evt_valid), 0);
        step(1, 8'hF0);
        check("r032_f0_noevt", 32'(evt_valid), 0);
        step(1, 8'h75);
        check("r032_evt", {evt_valid, evt_code, evt_ext, evt_break}, {1'b1, 8'h75, 1'b1, 1'b1});
        step(0, 8'h00);
        check("r032_single", 32'(evt_valid), 0);

        evt_ready = 0;
        for (int i = 0; i < 6; i++) begin
            sent[i] = letter_codes[$urandom_range(0, 25)];
            step(1, sent[i]);
        end
        check("r033_valid", 32'(evt_valid), 1);
        check("r033_drop", 32'(drop_cnt), 2);
        check("r033_head0", 32'(evt_code), 32'(sent[0]));
        evt_ready = 1;
        for (int i = 1; i < 4; i++) begin
            step(0, 8'h00);
            check("r033_order", 32'(evt_code), 32'(sent[i]));
        end
        step(0, 8'h00);
        check("r033_drained", 32'(evt_valid), 0);

        step(1, 8'h1C);
        step(1, 8'h1C);
        check("r034_repeat", 32'(evt_repeat), 1);
        step(1, 8'hF0);
        pulse_reset("r034_rst");
        step(1, 8'h1C);
        check("r034_after_rst", {evt_valid, evt_code, evt_break, evt_repeat}, {1'b1, 8'h1C, 1'b0, 1'b0});
        check("r034_drop", 32'(drop_cnt), 0);
        step(0, 8'h00);

        step(1, 8'hAA);
        check("r035_aa", 32'(evt_valid), 0);
        step(1, 8'hFA);
        check("r035_fa", 32'(evt_valid), 0);

        for (int n = 0; n < 600; n++) begin
            evt_ready = ($urandom_range(0, 2) != 0);
            cat = $urandom_range(0, 9);
            case (cat)
                0, 1:    b = letter_codes[$urandom_range(0, 25)];
                2:       b = digit_codes[$urandom_range(0, 9)];
                3:       b = ($urandom_range(0, 1) != 0) ? 8'h29 : 8'h5A;
                4:       b = ($urandom_range(0, 2) == 0) ? 8'h12 : (($urandom_range(0, 1) != 0) ? 8'h59 : 8'h14);
                5:       b = 8'hE0;
                6:       b = 8'hF0;
                7:       b = junk_codes[$urandom_range(0, 6)];
                default: b = 8'($urandom_range(0, 255));
            endcase
            step($urandom_range(0, 3) != 0, b);
            if (n == 300) pulse_reset("rand_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
